// File: rtl/button_ctrl_pkg.sv
// Shared definitions for the button service engine.
//   state_e        : service FSM states
//   PIO_ADDR_*     : word addresses of the push-button PIO slave registers
package button_ctrl_pkg;

  typedef enum logic [2:0] {
    StInit,
    StIdle,
    StMaskWr,
    StRdAddr,
    StRdCap,
    StClr,
    StPush,
    StHold
  } state_e;

  localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
  localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

endpackage

// File: rtl/button_service_ctrl_if.sv
// Avalon-MM link between the button service engine (master) and the PIO s1 port (slave).
//   pio_irq        : PIO interrupt, slave -> master
//   pio_address    : word address, master -> slave
//   pio_chipselect : write qualifier, master -> slave
//   pio_write_n    : active-low write, master -> slave
//   pio_writedata  : write data, master -> slave
//   pio_readdata   : registered read data, slave -> master
interface button_service_ctrl_if #(
  parameter int unsigned WIDTH = 4
);

  logic             pio_irq;
  logic [1:0]       pio_address;
  logic             pio_chipselect;
  logic             pio_write_n;
  logic [WIDTH-1:0] pio_writedata;
  logic [WIDTH-1:0] pio_readdata;

  modport master (
    input  pio_irq,
    input  pio_readdata,
    output pio_address,
    output pio_chipselect,
    output pio_write_n,
    output pio_writedata
  );

  modport slave (
    output pio_irq,
    output pio_readdata,
    input  pio_address,
    input  pio_chipselect,
    input  pio_write_n,
    input  pio_writedata
  );

endinterface

// File: rtl/button_evt_fifo.sv
// Synchronous event FIFO holding captured button bitmasks.
//   clk, reset : clock, synchronous active-high flush
//   push/wdata : enqueue (ignored while full)
//   pop        : dequeue head (ignored while empty)
//   rdata      : head entry
//   full/empty : status
//   count      : occupancy, 0..FIFO_DEPTH
module button_evt_fifo #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned AW        = $clog2(FIFO_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_en, pop_en;

  assign full    = (count_q == (AW + 1)'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign push_en = push & ~full;
  assign pop_en  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_en)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push_en, pop_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/button_service_ctrl.sv
// Hardware interrupt-service engine for the push-button PIO. Programs the irq mask, services
// irq by reading and clearing edge_capture, and queues each captured bitmask as an event.
//   clk, reset  : clock, synchronous active-high reset
//   pio         : Avalon-MM master towards the PIO s1 port
//   mask_in     : new irq mask, latched on a mask_update pulse
//   mask_update : one-cycle request to write mask_in to the PIO
//   evt_valid   : event FIFO non-empty
//   evt_ready   : consumer accepts head event
//   evt_data    : head event, bit i = button i edge
//   evt_count   : FIFO occupancy
//   busy        : engine not idle
module button_service_ctrl
  import button_ctrl_pkg::*;
#(
  parameter int unsigned      WIDTH      = 4,
  parameter int unsigned      FIFO_DEPTH = 4,
  parameter logic [WIDTH-1:0] MASK_INIT  = 4'hF,
  parameter int unsigned      HOLDOFF    = 0,
  localparam int unsigned     CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         reset,
  button_service_ctrl_if.master        pio,
  input  logic [WIDTH-1:0]             mask_in,
  input  logic                         mask_update,
  output logic                         evt_valid,
  input  logic                         evt_ready,
  output logic [WIDTH-1:0]             evt_data,
  output logic [CW-1:0]                evt_count,
  output logic                         busy
);

  localparam int unsigned   HW        = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = (HOLDOFF > 0) ? HW'(HOLDOFF - 1) : '0;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             mask_pend_q, mask_pend_d;
  logic [HW-1:0]    hold_q, hold_d;

  logic [1:0]       bus_addr;
  logic             bus_cs, bus_wr_n;
  logic [WIDTH-1:0] bus_wdata;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [WIDTH-1:0] fifo_rdata;
  logic [CW-1:0]    fifo_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StInit;
      cap_q       <= '0;
      mask_q      <= MASK_INIT;
      mask_pend_q <= 1'b0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      cap_q       <= cap_d;
      mask_q      <= mask_d;
      mask_pend_q <= mask_pend_d;
      hold_q      <= hold_d;
    end
  end

  // Mask request latch: last pulse wins, and a pulse landing in MaskWr re-arms the request.
  always_comb begin
    mask_d      = mask_q;
    mask_pend_d = mask_pend_q;
    if (state_q == StMaskWr) mask_pend_d = 1'b0;
    if (mask_update) begin
      mask_d      = mask_in;
      mask_pend_d = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    cap_d     = cap_q;
    hold_d    = hold_q;
    fifo_push = 1'b0;
    bus_addr  = PIO_ADDR_DATA;
    bus_cs    = 1'b0;
    bus_wr_n  = 1'b1;
    bus_wdata = '0;
    unique case (state_q)
      StInit: begin
        bus_addr  = PIO_ADDR_MASK;
        bus_cs    = 1'b1;
        bus_wr_n  = 1'b0;
        bus_wdata = MASK_INIT;
        state_d   = StIdle;
      end
      StIdle: begin
        if (mask_pend_q) begin
          state_d = StMaskWr;
        end else if (pio.pio_irq && !fifo_full) begin
          // A full FIFO defers service; the PIO keeps OR-merging edges meanwhile.
          state_d = StRdAddr;
        end
      end
      StMaskWr: begin
        bus_addr  = PIO_ADDR_MASK;
        bus_cs    = 1'b1;
        bus_wr_n  = 1'b0;
        bus_wdata = mask_q;
        state_d   = StIdle;
      end
      StRdAddr: begin
        bus_addr = PIO_ADDR_EDGE;
        state_d  = StRdCap;
      end
      StRdCap: begin
        // Read data was registered by the PIO at the end of RdAddr.
        bus_addr = PIO_ADDR_EDGE;
        cap_d    = pio.pio_readdata;
        state_d  = (pio.pio_readdata == '0) ? StIdle : StClr;
      end
      StClr: begin
        // Clear only the captured bits so later edges on other buttons stay pending.
        bus_addr  = PIO_ADDR_EDGE;
        bus_cs    = 1'b1;
        bus_wr_n  = 1'b0;
        bus_wdata = cap_q;
        state_d   = StPush;
      end
      StPush: begin
        fifo_push = 1'b1;
        if (HOLDOFF > 0) begin
          hold_d  = HOLD_LOAD;
          state_d = StHold;
        end else begin
          state_d = StIdle;
        end
      end
      StHold: begin
        if (hold_q == '0) state_d = StIdle;
        else              hold_d  = hold_q - 1'b1;
      end
      default: state_d = StInit;
    endcase
  end

  // Reset forces the bus and event outputs to their idle values immediately.
  assign pio.pio_address    = reset ? PIO_ADDR_DATA : bus_addr;
  assign pio.pio_chipselect = ~reset & bus_cs;
  assign pio.pio_write_n    = reset | bus_wr_n;
  assign pio.pio_writedata  = reset ? '0 : bus_wdata;

  assign evt_valid = ~reset & ~fifo_empty;
  assign evt_data  = reset ? '0 : fifo_rdata;
  assign evt_count = reset ? '0 : fifo_count;
  assign busy      = reset | (state_q != StIdle);
  assign fifo_pop  = evt_valid & evt_ready;

  button_evt_fifo #(
    .WIDTH      (WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .wdata (cap_q),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule
